mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, bus cycles to wait for bus_ack before declaring a bus error.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_wdata  in  32  EX result (ALU result, or store data when i_memop is a store).
REQ-005 i_addr  in  5  destination register address.
REQ-006 i_we  in  1  register write enable.
REQ-007 i_memop  in  4  operation code: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as none.
REQ-008 i_maddr  in  32  effective memory byte address.
REQ-009 o_wdata, o_addr, o_we  out  32/5/1  writeback data, register address and write enable toward MEM/WB.
REQ-010 stall_req  out  1  pipeline stall request.
REQ-011 bus_req, bus_we  out  1/1  data-bus request and write strobe.
REQ-012 bus_sel  out  4  byte lanes; bit 3 = byte address 0 (big-endian).
REQ-013 bus_addr, bus_wdata  out  32/32  word address (bits 1:0 forced to 0) and store data.
REQ-014 bus_rdata, bus_ack  in  32/1  read data and one-cycle completion strobe.
REQ-015 excp_adel, excp_ades, excp_buserr  out  1/1/1  one-cycle exception flags.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 IDLE, memop none: o_wdata/o_addr/o_we combinationally equal i_wdata/i_addr/i_we; stall_req=0; no state change.
REQ-018 IDLE, memop valid: alignment check — halfword requires i_maddr[0]=0, word requires i_maddr[1:0]=0.
REQ-019 Misaligned: no bus access; o_we=0; stall_req=0; excp_adel (load) or excp_ades (store) asserted for that cycle; remain IDLE.
REQ-020 Aligned: stall_req=1 combinationally in that cycle; next edge enters ACCESS with bus_req, bus_we, bus_sel, bus_addr and bus_wdata registered.
REQ-021 bus_sel: byte ops = 1000>>i_maddr[1:0]; half ops = 1100 when i_maddr[1]=0, else 0011; word ops = 1111.
REQ-022 Store data replication: SB = {4{byte}}; SH = {2{half}}; SW = word.
REQ-023 ACCESS: stall_req=1; bus outputs held stable; timeout counter increments each cycle.
REQ-024 bus_ack in ACCESS: load data captured and extracted per lane; bus_req cleared; next state DONE.
REQ-025 LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
REQ-026 DONE, load: o_wdata = extracted data, o_we = i_we.
REQ-027 DONE, store: o_we = 0.
REQ-028 DONE: stall_req=0; next state IDLE. The pipeline advances on this edge, so the held op is not re-issued.
REQ-029 Timeout: counter reaching ACK_TIMEOUT without bus_ack → bus_req=0, DONE with o_we=0 and excp_buserr=1 for the DONE cycle.
REQ-030 bus_ack outside ACCESS is ignored.
REQ-031 bus_ack in the same cycle the counter reaches ACK_TIMEOUT: ack wins and no error is raised.
REQ-032 Inputs are held stable by the upstream stall while stall_req=1; the block does not re-sample them mid-access.

Reset
REQ-033 rst takes effect at any state, including mid-ACCESS.
REQ-034 Next edge after rst: state=IDLE, bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, counter=0, captured data=0.
REQ-035 While rst=1: o_wdata=0, o_addr=0, o_we=0, stall_req=0, all excp_* =0.

Verification
REQ-036 ALU op: memop=0, i_wdata=0x12345678, i_addr=5, i_we=1 → same-cycle o_* pass-through; stall_req=0; bus_req never rises.
REQ-037 LB sign-extend: i_maddr=0x101, bus_rdata=0x11F02233, ack 3 cycles after bus_req → bus_sel=0100, bus_addr=0x100, o_wdata=0xFFFFFFF0.
REQ-038 LB sign-extend, stall timing: same stimulus as REQ-037 → stall_req high 4 cycles.
REQ-039 SH: i_maddr=0x202, i_wdata=0x0000ABCD → bus_we=1, bus_sel=0011, bus_wdata=0xABCDABCD, o_we=0 in DONE.
REQ-040 Misaligned LW at 0x3 → excp_adel=1 one cycle, no bus_req, o_we=0.
REQ-041 Timeout: ACK_TIMEOUT=4, ack withheld → bus_req drops after 4 ACCESS cycles, excp_buserr=1 one cycle, o_we=0.
REQ-042 rst asserted in the second ACCESS cycle → next edge bus_req=0, IDLE; a later ack is ignored.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit between EX and MEM/WB. It issues one data-bus access per memory op,
// stalls the pipeline until bus_ack or timeout, and extracts big-endian load data.
module mem_lsu #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_addr,
  input  logic        i_we,
  input  logic [3:0]  i_memop,
  input  logic [31:0] i_maddr,
  output logic [31:0] o_wdata,
  output logic [4:0]  o_addr,
  output logic        o_we,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        excp_adel,
  output logic        excp_ades,
  output logic        excp_buserr
);

  // state  | meaning
  // IDLE   | accept the EX op: pass through, flag misalignment, or issue a bus access
  // ACCESS | bus_req held, waiting for bus_ack or the ack timeout
  // DONE   | one cycle presenting load data / store completion / bus error

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_nx;

  logic          is_load, is_store, is_half, is_word, misalign;
  logic [3:0]    sel_d;
  logic [31:0]   wdata_d;
  logic          issue, take, tmo;

  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic [3:0]    op_q;
  logic [1:0]    off_q;
  logic          err_q;
  logic          load_q;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   rd_ext;

  // decode of the incoming op
  always_comb begin
    is_load  = (i_memop >= OP_LB) && (i_memop <= OP_LW);
    is_store = (i_memop >= OP_SB) && (i_memop <= OP_SW);
    is_half  = (i_memop == OP_LH) || (i_memop == OP_LHU) || (i_memop == OP_SH);
    is_word  = (i_memop == OP_LW) || (i_memop == OP_SW);
    misalign = (is_half && i_maddr[0]) || (is_word && (i_maddr[1:0] != 2'b00));
  end

  // byte lanes and replicated store data; lane 3 is byte address 0
  always_comb begin
    sel_d   = 4'b0000;
    wdata_d = i_wdata;
    case (i_memop)
      OP_LB, OP_LBU, OP_SB: begin
        sel_d   = 4'b1000 >> i_maddr[1:0];
        wdata_d = {4{i_wdata[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel_d   = i_maddr[1] ? 4'b0011 : 4'b1100;
        wdata_d = {2{i_wdata[15:0]}};
      end
      OP_LW, OP_SW: begin
        sel_d   = 4'b1111;
        wdata_d = i_wdata;
      end
      default: begin
        sel_d   = 4'b0000;
        wdata_d = i_wdata;
      end
    endcase
  end

  // lane extraction of returned data, using the op latched at issue
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = bus_rdata[31:24];
      2'd1:    rd_byte = bus_rdata[23:16];
      2'd2:    rd_byte = bus_rdata[15:8];
      default: rd_byte = bus_rdata[7:0];
    endcase
    rd_half = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    case (op_q)
      OP_LB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  rd_ext = {24'd0, rd_byte};
      OP_LH:   rd_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  rd_ext = {16'd0, rd_half};
      OP_LW:   rd_ext = bus_rdata;
      default: rd_ext = 32'd0;
    endcase
  end

  assign load_q = (op_q >= OP_LB) && (op_q <= OP_LW);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    o_wdata     = i_wdata;
    o_addr      = i_addr;
    o_we        = 1'b0;
    stall_req   = 1'b0;
    excp_adel   = 1'b0;
    excp_ades   = 1'b0;
    excp_buserr = 1'b0;
    issue       = 1'b0;
    take        = 1'b0;
    tmo         = 1'b0;
    case (state)
      IDLE: begin
        if (!is_load && !is_store) begin
          o_we = i_we;
        end else if (misalign) begin
          excp_adel = is_load;
          excp_ades = is_store;
        end else begin
          stall_req = 1'b1;
          issue     = 1'b1;
          state_nx  = ACCESS;
        end
      end
      ACCESS: begin
        stall_req = 1'b1;
        // an ack arriving on the last allowed cycle still completes normally
        if (bus_ack) begin
          take     = 1'b1;
          state_nx = DONE;
        end else if (cnt == CNT_LAST) begin
          tmo      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        if (err_q) begin
          excp_buserr = 1'b1;
        end else if (load_q) begin
          o_we    = i_we;
          o_wdata = rdata_q;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      o_wdata     = 32'd0;
      o_addr      = 5'd0;
      o_we        = 1'b0;
      stall_req   = 1'b0;
      excp_adel   = 1'b0;
      excp_ades   = 1'b0;
      excp_buserr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      cnt       <= '0;
      rdata_q   <= 32'd0;
      op_q      <= 4'd0;
      off_q     <= 2'd0;
      err_q     <= 1'b0;
    end else if (issue) begin
      bus_req   <= 1'b1;
      bus_we    <= is_store;
      bus_sel   <= sel_d;
      bus_addr  <= {i_maddr[31:2], 2'b00};
      bus_wdata <= wdata_d;
      cnt       <= '0;
      op_q      <= i_memop;
      off_q     <= i_maddr[1:0];
      err_q     <= 1'b0;
    end else if (take) begin
      bus_req <= 1'b0;
      bus_we  <= 1'b0;
      rdata_q <= rd_ext;
      cnt     <= cnt + 1'b1;
    end else if (tmo) begin
      bus_req <= 1'b0;
      bus_we  <= 1'b0;
      err_q   <= 1'b1;
      cnt     <= cnt + 1'b1;
    end else if (state == ACCESS) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: per-cycle expectations derived from the op rules (lane masks,
// replication, extraction, ack latency vs timeout) compared against the DUT every cycle.
module tb_mem_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_wdata, i_maddr, bus_rdata;
  logic [4:0]  i_addr;
  logic        i_we, bus_ack;
  logic [3:0]  i_memop;
  logic [31:0] o_wdata, bus_addr, bus_wdata;
  logic [4:0]  o_addr;
  logic        o_we, stall_req, bus_req, bus_we;
  logic [3:0]  bus_sel;
  logic        excp_adel, excp_ades, excp_buserr;

  always #5 clk = ~clk;

  mem_lsu #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_wdata(i_wdata), .i_addr(i_addr), .i_we(i_we),
    .i_memop(i_memop), .i_maddr(i_maddr), .o_wdata(o_wdata), .o_addr(o_addr),
    .o_we(o_we), .stall_req(stall_req), .bus_req(bus_req), .bus_we(bus_we),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .excp_adel(excp_adel),
    .excp_ades(excp_ades), .excp_buserr(excp_buserr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_owdata, exp_baddr, exp_bwdata;
  logic [4:0]  exp_oaddr;
  logic [3:0]  exp_bsel;
  logic        exp_owe, exp_stall, exp_breq, exp_bwe, exp_adel, exp_ades, exp_berr;
  logic        chk_od, chk_breq, chk_bus, chk_bwd;

  int          stall_tot = 0, breq_tot = 0, adel_tot = 0, berr_tot = 0;
  logic [3:0]  last_sel;
  logic [31:0] last_baddr, last_bwd, last_owd;
  logic        last_bwe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
    check("o_we", {31'd0, o_we}, {31'd0, exp_owe});
    check("excp_adel", {31'd0, excp_adel}, {31'd0, exp_adel});
    check("excp_ades", {31'd0, excp_ades}, {31'd0, exp_ades});
    check("excp_buserr", {31'd0, excp_buserr}, {31'd0, exp_berr});
    if (chk_breq) check("bus_req", {31'd0, bus_req}, {31'd0, exp_breq});
    if (chk_bus) begin
      check("bus_we", {31'd0, bus_we}, {31'd0, exp_bwe});
      check("bus_sel", {28'd0, bus_sel}, {28'd0, exp_bsel});
      check("bus_addr", bus_addr, exp_baddr);
    end
    if (chk_bwd) check("bus_wdata", bus_wdata, exp_bwdata);
    if (chk_od) begin
      check("o_wdata", o_wdata, exp_owdata);
      check("o_addr", {27'd0, o_addr}, {27'd0, exp_oaddr});
    end
    if (stall_req === 1'b1) stall_tot++;
    if (excp_adel === 1'b1) adel_tot++;
    if (excp_buserr === 1'b1) berr_tot++;
    if (bus_req === 1'b1) begin
      breq_tot++;
      last_sel = bus_sel; last_baddr = bus_addr; last_bwd = bus_wdata; last_bwe = bus_we;
    end
    if (o_we === 1'b1 && stall_req === 1'b0) last_owd = o_wdata;
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_clear();
    exp_owdata = 32'd0; exp_oaddr = 5'd0; exp_owe = 1'b0; exp_stall = 1'b0;
    exp_breq = 1'b0; exp_bwe = 1'b0; exp_bsel = 4'd0; exp_baddr = 32'd0; exp_bwdata = 32'd0;
    exp_adel = 1'b0; exp_ades = 1'b0; exp_berr = 1'b0;
    chk_od = 1'b0; chk_breq = 1'b1; chk_bus = 1'b0; chk_bwd = 1'b0;
  endtask

  // access width in bytes: 0 for non-memory codes
  function automatic int m_size(input logic [3:0] op);
    if (op == 1 || op == 2 || op == 6) return 1;
    if (op == 3 || op == 4 || op == 7) return 2;
    if (op == 5 || op == 8) return 4;
    return 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [1:0] off);
    int w, s;
    w = m_size(op);
    s = ((1 << w) - 1) << (4 - w - int'(off));
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_store(input logic [3:0] op, input logic [31:0] wd);
    if (m_size(op) == 1) return {24'd0, wd[7:0]} * 32'h01010101;
    if (m_size(op) == 2) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_extract(input logic [3:0] op, input logic [1:0] off,
                                            input logic [31:0] rd);
    int w;
    logic [31:0] mask, v;
    w = m_size(op);
    mask = (w == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * w)) - 32'h1);
    v = (rd >> (8 * (4 - w - int'(off)))) & mask;
    if ((op == 1 || op == 3) && v[8 * w - 1]) v = v | ~mask;
    return v;
  endfunction

  // one EX op from IDLE through completion; lat = bus_req cycle carrying the ack
  task automatic run_op(input logic [3:0] op, input logic [31:0] maddr, input logic [31:0] wd,
                        input logic [4:0] ra, input logic we, input int lat,
                        input logic [31:0] rd);
    bit ld, st, mis, err;
    int w, n;
    w   = m_size(op);
    ld  = (op >= 1 && op <= 5);
    st  = (op >= 6 && op <= 8);
    mis = (w == 2 && maddr[0]) || (w == 4 && maddr[1:0] != 2'b00);
    i_memop = op; i_maddr = maddr; i_wdata = wd; i_addr = ra; i_we = we;
    bus_ack = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    exp_clear();
    if (!ld && !st) begin
      exp_owe = we; chk_od = 1'b1; exp_owdata = wd; exp_oaddr = ra;
      cyc();
      return;
    end
    if (mis) begin
      exp_adel = ld; exp_ades = st;
      cyc();
      return;
    end
    exp_stall = 1'b1;
    cyc();
    err = (lat > TO);
    n   = err ? TO : lat;
    for (int k = 1; k <= n; k++) begin
      exp_clear();
      exp_stall = 1'b1; exp_breq = 1'b1; chk_bus = 1'b1; chk_bwd = st;
      exp_bwe = st; exp_bsel = m_sel(op, maddr[1:0]);
      exp_baddr = maddr & ~32'h3; exp_bwdata = m_store(op, wd);
      bus_ack = (k == lat);
      bus_rdata = (k == lat) ? rd : $urandom;
      cyc();
    end
    exp_clear();
    bus_ack = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    exp_berr = err;
    exp_owe  = ld && !err && we;
    chk_od   = exp_owe;
    exp_owdata = m_extract(op, maddr[1:0], rd);
    exp_oaddr  = ra;
    cyc();
    bus_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, b0, a0, e0;
    logic [31:0] ma;
    logic [3:0]  op;
    logic [1:0]  off;

    rst = 1'b1; i_memop = 4'd5; i_maddr = 32'h40; i_wdata = 32'hDEADBEEF;
    i_addr = 5'd9; i_we = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
    exp_clear();
    chk_od = 1'b1; chk_bus = 1'b1; chk_bwd = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // ALU pass-through
    b0 = breq_tot;
    run_op(4'd0, 32'h0, 32'h12345678, 5'd5, 1'b1, 1, 32'h0);
    check("alu_breq_cycles", 32'(breq_tot - b0), 32'd0);

    // LB sign-extend at 0x101, ack on 3rd bus_req cycle
    s0 = stall_tot;
    run_op(4'd1, 32'h101, 32'h0, 5'd7, 1'b1, 3, 32'h11F02233);
    check("lb_sel", {28'd0, last_sel}, 32'h4);
    check("lb_addr", last_baddr, 32'h100);
    check("lb_data", last_owd, 32'hFFFFFFF0);
    check("lb_stall_cycles", 32'(stall_tot - s0), 32'd4);

    // SH at 0x202
    run_op(4'd7, 32'h202, 32'h0000ABCD, 5'd3, 1'b1, 2, 32'h0);
    check("sh_we", {31'd0, last_bwe}, 32'd1);
    check("sh_sel", {28'd0, last_sel}, 32'h3);
    check("sh_wdata", last_bwd, 32'hABCDABCD);

    // misaligned LW at 0x3
    a0 = adel_tot; b0 = breq_tot;
    run_op(4'd5, 32'h3, 32'h0, 5'd4, 1'b1, 1, 32'h0);
    check("adel_cycles", 32'(adel_tot - a0), 32'd1);
    check("mis_breq_cycles", 32'(breq_tot - b0), 32'd0);

    // timeout with ack withheld
    e0 = berr_tot; b0 = breq_tot;
    run_op(4'd5, 32'h40, 32'h0, 5'd6, 1'b1, TO + 5, 32'h0);
    check("tmo_breq_cycles", 32'(breq_tot - b0), 32'd4);
    check("tmo_berr_cycles", 32'(berr_tot - e0), 32'd1);

    // ack on the final allowed cycle wins over timeout
    e0 = berr_tot;
    run_op(4'd5, 32'h44, 32'h0, 5'd8, 1'b1, TO, 32'hCAFEF00D);
    check("edge_berr_cycles", 32'(berr_tot - e0), 32'd0);
    check("edge_data", last_owd, 32'hCAFEF00D);

    // reset in the second ACCESS cycle, then a stray ack
    b0 = breq_tot;
    i_memop = 4'd5; i_maddr = 32'h80; i_wdata = 32'h0; i_addr = 5'd2; i_we = 1'b1;
    bus_ack = 1'b0;
    exp_clear(); exp_stall = 1'b1;
    cyc();
    exp_clear(); exp_stall = 1'b1; exp_breq = 1'b1;
    cyc();
    rst = 1'b1;
    exp_clear(); chk_breq = 1'b0; chk_od = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_memop = 4'd0; i_wdata = 32'h5A5A0000 + 32'(k); i_addr = 5'd11; i_we = 1'b1;
      bus_ack = (k == 0);
      exp_clear(); exp_owe = 1'b1; chk_od = 1'b1; exp_owdata = i_wdata; exp_oaddr = 5'd11;
      cyc();
    end
    bus_ack = 1'b0;
    check("rst_breq_cycles", 32'(breq_tot - b0), 32'd2);

    // randomized ops
    for (int t = 0; t < 400; t++) begin
      op  = 4'($urandom_range(0, 15));
      ma  = $urandom;
      off = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (m_size(op) == 2) off[0] = 1'b0;
        if (m_size(op) == 4) off = 2'b00;
      end
      ma[1:0] = off;
      run_op(op, ma, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(1, TO + 1), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
